// File: rtl/qar_bus_pkg.sv
// Shared types and constants for the qar data-bus responder: FSM states,
// the error read-data value and the jitter LFSR seed/taps.
package qar_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } dmem_state_e;

   localparam logic [31:0] DMEM_ERR_RDATA = 32'h0000_0000;

   // Fibonacci taps 8,6,5,4 expressed as a mask over state bits [7:0]
   localparam logic [7:0] LFSR_SEED = 8'hA5;
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/qar_dmem_ram.sv
// Single-port synchronous word RAM: one write port and a registered read.
// Contents are never cleared by reset.
module qar_dmem_ram #(
   parameter int DEPTH      = 256,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  i_we,
   input  logic                  i_re,
   input  logic [ADDR_WIDTH-1:0] i_idx,
   input  logic [31:0]           i_wdata,
   output logic [31:0]           o_rdata
);

   logic [31:0] r_mem [DEPTH];
   logic [31:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_idx] <= i_wdata;
      end
      if (i_re) begin
         r_rdata <= r_mem[i_idx];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/qar_dmem_responder.sv
// Data-bus responder for the qar_core mem_* interface with programmable wait
// states and range/alignment error flagging. Optional macro: QAR_DMEM_JITTER_EN.
module qar_dmem_responder
   import qar_bus_pkg::*;
#(
   parameter int          DEPTH       = 256,
   parameter int          ADDR_WIDTH  = 8,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_valid,
   input  logic        mem_we,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic        mem_err,
   output logic        busy
);

   localparam logic [32:0] SPAN    = 33'(DEPTH) << 2;
   localparam logic [4:0]  WS_LOAD = 5'(WAIT_STATES);

   dmem_state_e           r_state;
   dmem_state_e           w_next;
   logic [4:0]            r_cnt;
   logic [4:0]            w_cnt_load;
   logic                  r_we;
   logic [31:0]           r_addr;
   logic [31:0]           r_wdata;
   logic                  r_ready;
   logic                  r_err;
   logic                  r_rd_ok;
   logic [31:0]           w_off;
   logic                  w_err;
   logic [ADDR_WIDTH-1:0] w_idx;
   logic                  w_in_resp;
   logic                  w_ram_we;
   logic                  w_ram_re;
   logic [31:0]           w_ram_rdata;

`ifdef QAR_DMEM_JITTER_EN
   logic [7:0] r_lfsr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lfsr <= LFSR_SEED;
      end else begin
         r_lfsr <= lfsr_next(r_lfsr);
      end
   end

   assign w_cnt_load = WS_LOAD + {3'b000, r_lfsr[1:0]};
`else
   assign w_cnt_load = WS_LOAD;
`endif

   // Decode always works on the latched address, never on the live bus
   assign w_off     = r_addr - BASE_ADDR;
   assign w_err     = ({1'b0, w_off} >= SPAN) || (r_addr[1:0] != 2'b00);
   assign w_idx     = w_off[ADDR_WIDTH+1:2];
   assign w_in_resp = (r_state == ST_RESP);
   assign w_ram_we  = w_in_resp && r_we && !w_err;
   assign w_ram_re  = w_in_resp && !r_we && !w_err;

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (mem_valid) begin
               w_next = (w_cnt_load == 5'd0) ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (r_cnt <= 5'd1) begin
               w_next = ST_RESP;
            end
         end
         ST_RESP: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // RESP is the last busy cycle; its closing edge commits the RAM access
   // and registers the one-cycle response strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= 5'd0;
         r_ready <= 1'b0;
         r_err   <= 1'b0;
         r_rd_ok <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == ST_IDLE && mem_valid) begin
            r_cnt <= w_cnt_load;
         end else if (r_state == ST_WAIT) begin
            r_cnt <= r_cnt - 5'd1;
         end
         r_ready <= w_in_resp;
         r_err   <= w_in_resp && w_err;
         r_rd_ok <= w_ram_re;
      end
   end

   always_ff @(posedge clk) begin
      if (r_state == ST_IDLE && mem_valid) begin
         r_we    <= mem_we;
         r_addr  <= mem_addr;
         r_wdata <= mem_wdata;
      end
   end

   qar_dmem_ram #(
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_ram_we),
      .i_re    (w_ram_re),
      .i_idx   (w_idx),
      .i_wdata (r_wdata),
      .o_rdata (w_ram_rdata)
   );

   assign mem_ready = r_ready;
   assign mem_err   = r_err;
   assign mem_rdata = r_rd_ok ? w_ram_rdata : DMEM_ERR_RDATA;
   assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_qar_dmem_responder.sv
// Directed bench for qar_dmem_responder: three instances with 0, 1 and 3 wait states.
module tb_qar_dmem_responder;

`ifdef QAR_DMEM_JITTER_EN
   localparam int JIT = 3;
`else
   localparam int JIT = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n [3];
   logic        valid [3];
   logic        we    [3];
   logic [31:0] addr  [3];
   logic [31:0] wdata [3];
   logic        ready [3];
   logic        err   [3];
   logic        busy  [3];
   logic [31:0] rdata [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   qar_dmem_responder #(.WAIT_STATES(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n[0]), .mem_valid(valid[0]), .mem_we(we[0]),
      .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_ready(ready[0]),
      .mem_rdata(rdata[0]), .mem_err(err[0]), .busy(busy[0]));

   qar_dmem_responder #(.WAIT_STATES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n[1]), .mem_valid(valid[1]), .mem_we(we[1]),
      .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_ready(ready[1]),
      .mem_rdata(rdata[1]), .mem_err(err[1]), .busy(busy[1]));

   qar_dmem_responder #(.WAIT_STATES(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n[2]), .mem_valid(valid[2]), .mem_we(we[2]),
      .mem_addr(addr[2]), .mem_wdata(wdata[2]), .mem_ready(ready[2]),
      .mem_rdata(rdata[2]), .mem_err(err[2]), .busy(busy[2]));

   typedef struct {
      int          d;
      bit          w;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      bit          exp_er;
      int          exp_lat;
   } vec_t;

   vec_t vt [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk_lat(input string name, input int act, input int lo);
      checks++;
      if (act < lo || act > lo + JIT) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, lo + JIT);
      end
   endtask

   // Latency is counted in cycles from the accepting edge to the ready cycle.
   task automatic xact(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat, output int bcnt);
      @(negedge clk);
      valid[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
      lat = 0; bcnt = 0; rd = 32'hxxxx_xxxx; er = 1'bx;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (busy[d]) bcnt++;
         if (ready[d]) begin
            lat = i; rd = rdata[d]; er = err[d];
            break;
         end
      end
      valid[d] = 1'b0;
   endtask

   logic [31:0] rd;
   logic        er;
   int          lat, bcnt, pulses, last;

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int d = 0; d < 3; d++) begin
         rst_n[d] = 1'b0; valid[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
      end

      vt[0]  = '{0, 1'b1, 32'h0000_0048, 32'h1234_5678, 32'h0,          1'b0, 1};
      vt[1]  = '{0, 1'b0, 32'h0000_0048, 32'h0,          32'h1234_5678, 1'b0, 1};
      vt[2]  = '{0, 1'b0, 32'h0000_0400, 32'h0,          32'h0,          1'b1, 1};
      vt[3]  = '{0, 1'b1, 32'h0000_004A, 32'hDEAD_BEEF, 32'h0,          1'b1, 1};
      vt[4]  = '{0, 1'b0, 32'h0000_0048, 32'h0,          32'h1234_5678, 1'b0, 1};
      vt[5]  = '{0, 1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 32'h0,          1'b0, 1};
      vt[6]  = '{0, 1'b0, 32'h0000_03FC, 32'h0,          32'hCAFE_F00D, 1'b0, 1};
      vt[7]  = '{0, 1'b0, 32'hFFFF_FFFC, 32'h0,          32'h0,          1'b1, 1};
      vt[8]  = '{0, 1'b0, 32'h0000_0049, 32'h0,          32'h0,          1'b1, 1};
      vt[9]  = '{2, 1'b1, 32'h0000_0004, 32'h0000_00EE, 32'h0,          1'b0, 4};
      vt[10] = '{1, 1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 32'h0,          1'b0, 2};
      vt[11] = '{1, 1'b0, 32'h0000_0010, 32'h0,          32'hA5A5_A5A5, 1'b0, 2};
      vt[12] = '{0, 1'b1, 32'h0000_0048, 32'h0BAD_F00D, 32'h0,          1'b0, 1};
      vt[13] = '{0, 1'b0, 32'h0000_0048, 32'h0,          32'h0BAD_F00D, 1'b0, 1};

      // Reset state
      repeat (2) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("rst_ready%0d", d), {31'b0, ready[d]}, 32'h0);
         chk($sformatf("rst_err%0d", d),   {31'b0, err[d]},   32'h0);
         chk($sformatf("rst_busy%0d", d),  {31'b0, busy[d]},  32'h0);
         chk($sformatf("rst_rdata%0d", d), rdata[d],          32'h0);
      end
      for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
      repeat (2) @(negedge clk);

      // Table-driven transactions
      for (int i = 0; i < 14; i++) begin
         xact(vt[i].d, vt[i].w, vt[i].a, vt[i].wd, rd, er, lat, bcnt);
         chk($sformatf("v%0d_rdata", i), rd, vt[i].exp_rd);
         chk($sformatf("v%0d_err", i), {31'b0, er}, {31'b0, vt[i].exp_er});
         chk_lat($sformatf("v%0d_latency", i), lat, vt[i].exp_lat);
         chk_lat($sformatf("v%0d_busy_cycles", i), bcnt, vt[i].exp_lat);
         @(negedge clk);
         chk($sformatf("v%0d_ready_one_cycle", i), {31'b0, ready[vt[i].d]}, 32'h0);
         chk($sformatf("v%0d_idle_rdata", i), rdata[vt[i].d], 32'h0);
         chk($sformatf("v%0d_idle_err", i), {31'b0, err[vt[i].d]}, 32'h0);
      end

      // Three wait states: address/data changes during WAIT are ignored
      @(negedge clk);
      valid[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h0000_0004;
      @(negedge clk);
      we[2] = 1'b1; addr[2] = 32'h0000_0048; wdata[2] = 32'hFFFF_FFFF;
      lat = 0; rd = 32'hxxxx_xxxx; er = 1'bx;
      for (int i = 1; i < 40; i++) begin
         @(negedge clk);
         if (ready[2]) begin lat = i; rd = rdata[2]; er = err[2]; break; end
      end
      valid[2] = 1'b0;
      chk("ws3_live_change_rdata", rd, 32'h0000_00EE);
      chk("ws3_live_change_err", {31'b0, er}, 32'h0);
      chk_lat("ws3_live_change_latency", lat, 4);
      xact(2, 1'b0, 32'h0000_0004, 32'h0, rd, er, lat, bcnt);
      chk("ws3_reread_0x04", rd, 32'h0000_00EE);

      // Back-to-back writes with valid held high, one wait state
      @(negedge clk);
      valid[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h0000_0100; wdata[1] = 32'h1000_0000;
      pulses = 0; last = 0;
      for (int c = 0; c < 200 && pulses < 10; c++) begin
         @(negedge clk);
         if (ready[1]) begin
`ifndef QAR_DMEM_JITTER_EN
            if (pulses > 0) chk($sformatf("b2b_gap%0d", pulses), c - last, 3);
`endif
            last = c;
            pulses++;
            if (pulses < 10) begin
               addr[1]  = 32'h0000_0100 + 32'(4 * pulses);
               wdata[1] = 32'h1000_0000 + 32'(pulses);
            end else begin
               valid[1] = 1'b0;
            end
         end
      end
      valid[1] = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (ready[1]) pulses++;
      end
      chk("b2b_pulse_count", pulses, 10);
      for (int k = 0; k < 10; k++) begin
         xact(1, 1'b0, 32'h0000_0100 + 32'(4 * k), 32'h0, rd, er, lat, bcnt);
         chk($sformatf("b2b_readback%0d", k), rd, 32'h1000_0000 + 32'(k));
      end

      // Reset asserted during WAIT of a write aborts it
      xact(2, 1'b1, 32'h0000_0010, 32'h1111_1111, rd, er, lat, bcnt);
      @(negedge clk);
      valid[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h0000_0010; wdata[2] = 32'h2222_2222;
      @(negedge clk);
      @(negedge clk);
      chk("abort_busy_before", {31'b0, busy[2]}, 32'h1);
      #2 rst_n[2] = 1'b0;
      #1;
      chk("abort_busy_async", {31'b0, busy[2]}, 32'h0);
      chk("abort_ready_async", {31'b0, ready[2]}, 32'h0);
      chk("abort_err_async", {31'b0, err[2]}, 32'h0);
      valid[2] = 1'b0;
      @(negedge clk);
      rst_n[2] = 1'b1;
      xact(2, 1'b0, 32'h0000_0010, 32'h0, rd, er, lat, bcnt);
      chk("abort_word_kept", rd, 32'h1111_1111);
      chk_lat("abort_next_latency", lat, 4);

`ifdef QAR_DMEM_JITTER_EN
      for (int k = 0; k < 64; k++) begin
         xact(1, 1'b0, 32'h0000_0010, 32'h0, rd, er, lat, bcnt);
         chk($sformatf("jit_rdata%0d", k), rd, 32'hA5A5_A5A5);
         chk_lat($sformatf("jit_latency%0d", k), lat, 2);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
